blood_ctrl: RTL and testbench
=============================

# blood_ctrl

Upstream controller for the blood-splash sprite renderer. Converts per-monster hit events into the `exist` / `state` / attack-coordinate signals that the renderer consumes, on two independent channels (monster 1, monster 2). Each channel:
- latches and clamps the hit position;
- steps a 3-frame animation paced by the per-frame strobe;
- retires the effect automatically.

## Interface
Parameters:
- FRAMES_PER_STATE, 6, frame strobes each animation frame is held (1..63)
- SCREEN_W, 640, visible width in pixels
- SCREEN_H, 480, visible height in pixels
- BLOOD_SIZE_HALF, 35, sprite half-size; clamp margin

Ports:
- Clk  in  1  system clock; the only clock
- Reset  in  1  reset: synchronous, active-low
- frame_tick  in  1  one-Clk pulse per video frame
- hit1, hit2  in  1  one-Clk hit pulse, per monster
- hit1_x, hit2_x  in  10  hit X position, pixels
- hit1_y, hit2_y  in  10  hit Y position, pixels
- blood1_exist, blood2_exist  out  1  animation active
- blood1_state, blood2_state  out  2  frame index 0..2
- monster1_attackx, monster2_attackx  out  10  clamped sprite centre X
- monster1_attacky, monster2_attacky  out  10  clamped sprite centre Y
- blood1_done, blood2_done  out  1  one-Clk pulse when an animation retires

## Operation
- The two channels are identical and fully independent. No shared state; simultaneous events on both channels are both serviced.
- Per-channel FSM states: IDLE, F0, F1, F2.
- IDLE -> F0 on hit. In that same edge:
  - latch the clamped coordinates;
  - clear the tick counter.
- Fn -> Fn+1 when the counter reaches FRAMES_PER_STATE-1 and frame_tick=1.
  - Otherwise frame_tick increments the counter.
  - Cycles without frame_tick leave the counter unchanged.
- F2 -> IDLE on its final tick. On that transition, pulse done for 1 cycle.
- Output mapping:
  - exist = (state != IDLE).
  - blood_state = 0/1/2 for F0/F1/F2, and 0 in IDLE.
- Clamping (unsigned 10-bit):
  - X clamped to [BLOOD_SIZE_HALF, SCREEN_W-BLOOD_SIZE_HALF], i.e. [35,605].
  - Y clamped to [BLOOD_SIZE_HALF, SCREEN_H-BLOOD_SIZE_HALF], i.e. [35,445].
  - This guarantees the renderer's `attack - 35` never underflows.
- Coordinates hold their last latched value in IDLE. They are not cleared on retire.
- hit and frame_tick in the same cycle: the hit wins. The state goes to F0 (or restarts there) and the counter clears; the tick is not counted.
- A hit in the retire cycle behaves per the Configuration section. When the hit is ignored, done still pulses and the channel goes IDLE.

## Timing
- Every output is a flop. There is no combinational path from any input to any output.
- Hit sampled at edge N:
  - exist=1, state=0 and the new coordinates are visible after edge N.
  - Latency is 1 Clk.
- Nominal animation length is 3×FRAMES_PER_STATE frame ticks. The first tick after the hit counts.
- Reset low at any edge, including mid-animation:
  - next state IDLE, counter 0;
  - all outputs 0: exist, state, done, attackx, attacky.
- Reset has priority over hit and frame_tick.

## Configuration
- Macro: BLOOD_RETRIGGER_EN.
- Defined:
  - a hit while in F0..F2 restarts the animation at F0;
  - it relatches the coordinates and clears the counter;
  - done does not pulse for the aborted animation.
- Undefined:
  - hits while not IDLE are ignored, including in the retire cycle;
  - coordinates are unchanged until the channel is IDLE.

## Structure
- Package blood_pkg:
  - enum blood_fsm_t {IDLE, F0, F1, F2};
  - constants BLOOD_SIZE_HALF=35, SCREEN_W=640, SCREEN_H=480;
  - clamp function for 10-bit coordinates.
- Sub-module blood_channel: one FSM, counter, clamp and latch. blood_ctrl instantiates it twice and only maps ports.

## Test plan
- Reset: hold Reset=0 for 3 Clk with hit1=1. Expect all outputs 0 and no done.
- Basic run: hit1 at (100,200), FRAMES_PER_STATE=6, then 18 frame_ticks.
  - exist high from edge+1, state 0→1→2 at ticks 6 and 12;
  - exist low and one-cycle done after tick 18;
  - coordinates (100,200) retained.
- Clamp: hit2 at (5,470), then at (639,0). Expect (35,445), then (605,35).
- Collisions:
  - hit1 with frame_tick in the same cycle: expect state 0 and counter 0.
  - hits on both channels in the same cycle: both start.
- Retrigger: hit1 at (300,300), 8 ticks (state 1), then hit1 at (400,100).
  - With BLOOD_RETRIGGER_EN: state 0, coordinates (400,100), retire 18 ticks later.
  - Without: state stays 1, coordinates (300,300), retire 10 ticks later.
- Mid-run reset: assert Reset during F2. Expect IDLE the next cycle and no done pulse.

Source files
------------

// File: rtl/blood_pkg.sv
// Shared types, screen constants and the coordinate clamp for the blood-splash controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   blood_fsm_t      per-channel animation state (IDLE, F0, F1, F2)
//   BLOOD_SIZE_HALF  sprite half-size, also the clamp margin
//   SCREEN_W/H       visible screen size in pixels
//   clamp10()        unsigned 10-bit clamp into [lo, hi]
package blood_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    F0   = 2'd1,
    F1   = 2'd2,
    F2   = 2'd3
  } blood_fsm_t;

  localparam int BLOOD_SIZE_HALF = 35;
  localparam int SCREEN_W        = 640;
  localparam int SCREEN_H        = 480;

  function automatic logic [9:0] clamp10(input logic [9:0] v,
                                         input logic [9:0] lo,
                                         input logic [9:0] hi);
    logic [9:0] r;
    r = v;
    if (v < lo) r = lo;
    else if (v > hi) r = hi;
    return r;
  endfunction

endpackage

// File: rtl/blood_channel.sv
// One blood-splash channel: latches a clamped hit position and steps a 3-frame animation paced by frame_tick.
// Latency: 1 Clk from hit to exist/state/coords; every output is a flop.
// Backpressure: none; hits while active are ignored, or restart the animation when BLOOD_RETRIGGER_EN is defined.
//
// Ports:
//   Clk, Reset (sync, active-low)   clock and reset
//   frame_tick                      one-Clk pulse per video frame
//   hit, hit_x, hit_y               hit pulse and raw position
//   exist, state                    animation active / frame index 0..2
//   attackx, attacky                clamped, latched sprite centre
//   done                            one-Clk pulse when the animation retires
//
// Build option: BLOOD_RETRIGGER_EN lets a hit during F0..F2 restart at F0.
module blood_channel #(
  parameter int FRAMES_PER_STATE = 6,
  parameter int SCREEN_W         = 640,
  parameter int SCREEN_H         = 480,
  parameter int BLOOD_SIZE_HALF  = 35
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic       hit,
  input  logic [9:0] hit_x,
  input  logic [9:0] hit_y,
  output logic       exist,
  output logic [1:0] state,
  output logic [9:0] attackx,
  output logic [9:0] attacky,
  output logic       done
);
  import blood_pkg::*;

  localparam logic [9:0] X_LO     = 10'(BLOOD_SIZE_HALF);
  localparam logic [9:0] X_HI     = 10'(SCREEN_W - BLOOD_SIZE_HALF);
  localparam logic [9:0] Y_LO     = 10'(BLOOD_SIZE_HALF);
  localparam logic [9:0] Y_HI     = 10'(SCREEN_H - BLOOD_SIZE_HALF);
  localparam logic [5:0] CNT_LAST = 6'(FRAMES_PER_STATE - 1);

  blood_fsm_t fsm_q, fsm_d;
  logic [5:0] cnt_q, cnt_d;
  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       exist_q, exist_d;
  logic [1:0] st_q, st_d;
  logic       done_q, done_d;
  logic       start;
  logic       last_tick;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      fsm_q   <= IDLE;
      cnt_q   <= 6'd0;
      x_q     <= 10'd0;
      y_q     <= 10'd0;
      exist_q <= 1'b0;
      st_q    <= 2'd0;
      done_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      exist_q <= exist_d;
      st_q    <= st_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    fsm_d     = fsm_q;
    cnt_d     = cnt_q;
    x_d       = x_q;
    y_d       = y_q;
    done_d    = 1'b0;
    exist_d   = 1'b0;
    st_d      = 2'd0;
    last_tick = frame_tick && (cnt_q == CNT_LAST);

`ifdef BLOOD_RETRIGGER_EN
    start = hit;
`else
    start = hit && (fsm_q == IDLE);
`endif

    // A starting hit outranks a frame tick in the same cycle: the tick is dropped.
    if (start) begin
      fsm_d = F0;
      cnt_d = 6'd0;
      x_d   = clamp10(hit_x, X_LO, X_HI);
      y_d   = clamp10(hit_y, Y_LO, Y_HI);
    end else if (fsm_q != IDLE && frame_tick) begin
      if (last_tick) begin
        cnt_d = 6'd0;
        case (fsm_q)
          F0:      fsm_d = F1;
          F1:      fsm_d = F2;
          default: begin
            fsm_d  = IDLE;
            done_d = 1'b1;
          end
        endcase
      end else begin
        cnt_d = cnt_q + 6'd1;
      end
    end

    // Outputs are registered from the next state so they appear one edge after the cause.
    exist_d = (fsm_d != IDLE);
    case (fsm_d)
      F1:      st_d = 2'd1;
      F2:      st_d = 2'd2;
      default: st_d = 2'd0;
    endcase
  end

  assign exist   = exist_q;
  assign state   = st_q;
  assign attackx = x_q;
  assign attacky = y_q;
  assign done    = done_q;

endmodule

// File: rtl/blood_ctrl.sv
// Two independent blood-splash channels (monster 1, monster 2) feeding the sprite renderer.
// Latency: 1 Clk from hit to outputs; all outputs registered.
// Backpressure: none; each channel handles its own hits, no shared state.
//
// Ports:
//   Clk, Reset (sync, active-low), frame_tick
//   hitN, hitN_x, hitN_y                     per-monster hit pulse and position
//   bloodN_exist, bloodN_state, bloodN_done  animation status
//   monsterN_attackx, monsterN_attacky       clamped sprite centre
//
// Build option: BLOOD_RETRIGGER_EN (see blood_channel).
module blood_ctrl #(
  parameter int FRAMES_PER_STATE = 6,
  parameter int SCREEN_W         = blood_pkg::SCREEN_W,
  parameter int SCREEN_H         = blood_pkg::SCREEN_H,
  parameter int BLOOD_SIZE_HALF  = blood_pkg::BLOOD_SIZE_HALF
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic       hit1,
  input  logic [9:0] hit1_x,
  input  logic [9:0] hit1_y,
  input  logic       hit2,
  input  logic [9:0] hit2_x,
  input  logic [9:0] hit2_y,
  output logic       blood1_exist,
  output logic [1:0] blood1_state,
  output logic [9:0] monster1_attackx,
  output logic [9:0] monster1_attacky,
  output logic       blood1_done,
  output logic       blood2_exist,
  output logic [1:0] blood2_state,
  output logic [9:0] monster2_attackx,
  output logic [9:0] monster2_attacky,
  output logic       blood2_done
);

  blood_channel #(
    .FRAMES_PER_STATE(FRAMES_PER_STATE),
    .SCREEN_W        (SCREEN_W),
    .SCREEN_H        (SCREEN_H),
    .BLOOD_SIZE_HALF (BLOOD_SIZE_HALF)
  ) u_ch1 (
    .Clk       (Clk),
    .Reset     (Reset),
    .frame_tick(frame_tick),
    .hit       (hit1),
    .hit_x     (hit1_x),
    .hit_y     (hit1_y),
    .exist     (blood1_exist),
    .state     (blood1_state),
    .attackx   (monster1_attackx),
    .attacky   (monster1_attacky),
    .done      (blood1_done)
  );

  blood_channel #(
    .FRAMES_PER_STATE(FRAMES_PER_STATE),
    .SCREEN_W        (SCREEN_W),
    .SCREEN_H        (SCREEN_H),
    .BLOOD_SIZE_HALF (BLOOD_SIZE_HALF)
  ) u_ch2 (
    .Clk       (Clk),
    .Reset     (Reset),
    .frame_tick(frame_tick),
    .hit       (hit2),
    .hit_x     (hit2_x),
    .hit_y     (hit2_y),
    .exist     (blood2_exist),
    .state     (blood2_state),
    .attackx   (monster2_attackx),
    .attacky   (monster2_attacky),
    .done      (blood2_done)
  );

endmodule

// File: tb/tb_blood_ctrl.sv
// Self-checking bench for blood_ctrl: directed steps followed by random traffic, compared every cycle
// against a tick-counting reference model (state = elapsed_ticks / FRAMES_PER_STATE).
// Honours BLOOD_RETRIGGER_EN the same way the design build does.
module tb_blood_ctrl;

  localparam int FPS   = 6;
  localparam int X_LO  = 35;
  localparam int X_HI  = 605;
  localparam int Y_LO  = 35;
  localparam int Y_HI  = 445;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       frame_tick = 1'b0;
  logic       hit1 = 1'b0, hit2 = 1'b0;
  logic [9:0] hit1_x = '0, hit1_y = '0, hit2_x = '0, hit2_y = '0;
  logic       blood1_exist, blood2_exist, blood1_done, blood2_done;
  logic [1:0] blood1_state, blood2_state;
  logic [9:0] monster1_attackx, monster1_attacky, monster2_attackx, monster2_attacky;

  int checks = 0;
  int failures = 0;

  // Reference model, per channel: active flag, frame ticks elapsed since start, latched coords, done.
  int act[2], tk[2], mx[2], my[2], dn[2];

  always #5 Clk = ~Clk;

  blood_ctrl #(.FRAMES_PER_STATE(FPS)) dut (
    .Clk             (Clk),
    .Reset           (Reset),
    .frame_tick      (frame_tick),
    .hit1            (hit1),
    .hit1_x          (hit1_x),
    .hit1_y          (hit1_y),
    .hit2            (hit2),
    .hit2_x          (hit2_x),
    .hit2_y          (hit2_y),
    .blood1_exist    (blood1_exist),
    .blood1_state    (blood1_state),
    .monster1_attackx(monster1_attackx),
    .monster1_attacky(monster1_attacky),
    .blood1_done     (blood1_done),
    .blood2_exist    (blood2_exist),
    .blood2_state    (blood2_state),
    .monster2_attackx(monster2_attackx),
    .monster2_attacky(monster2_attacky),
    .blood2_done     (blood2_done)
  );

  function automatic int clampi(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic model_ch(input int c, input logic h, input int x, input int y);
    bit can_start;
`ifdef BLOOD_RETRIGGER_EN
    can_start = 1'b1;
`else
    can_start = (act[c] == 0);
`endif
    dn[c] = 0;
    if (!Reset) begin
      act[c] = 0; tk[c] = 0; mx[c] = 0; my[c] = 0;
    end else if (h && can_start) begin
      act[c] = 1; tk[c] = 0;
      mx[c] = clampi(x, X_LO, X_HI);
      my[c] = clampi(y, Y_LO, Y_HI);
    end else if (act[c] != 0 && frame_tick) begin
      tk[c]++;
      if (tk[c] == 3 * FPS) begin
        act[c] = 0; tk[c] = 0; dn[c] = 1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: update the model with the inputs the DUT sampled, then check all outputs 1 time unit later.
  task automatic cyc();
    @(posedge Clk);
    model_ch(0, hit1, int'(hit1_x), int'(hit1_y));
    model_ch(1, hit2, int'(hit2_x), int'(hit2_y));
    #1;
    chk("exist1", 32'(blood1_exist), 32'(act[0]));
    chk("state1", 32'(blood1_state), 32'(act[0] != 0 ? tk[0] / FPS : 0));
    chk("x1",     32'(monster1_attackx), 32'(mx[0]));
    chk("y1",     32'(monster1_attacky), 32'(my[0]));
    chk("done1",  32'(blood1_done), 32'(dn[0]));
    chk("exist2", 32'(blood2_exist), 32'(act[1]));
    chk("state2", 32'(blood2_state), 32'(act[1] != 0 ? tk[1] / FPS : 0));
    chk("x2",     32'(monster2_attackx), 32'(mx[1]));
    chk("y2",     32'(monster2_attacky), 32'(my[1]));
    chk("done2",  32'(blood2_done), 32'(dn[1]));
  endtask

  task automatic hit_ch1(input int x, input int y);
    hit1 = 1'b1; hit1_x = 10'(x); hit1_y = 10'(y);
    cyc();
    hit1 = 1'b0;
  endtask

  task automatic hit_ch2(input int x, input int y);
    hit2 = 1'b1; hit2_x = 10'(x); hit2_y = 10'(y);
    cyc();
    hit2 = 1'b0;
  endtask

  // n frame ticks, each followed by one idle cycle so the hold-without-tick path is exercised.
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1; cyc();
      frame_tick = 1'b0; cyc();
    end
  endtask

  initial begin
    for (int c = 0; c < 2; c++) begin
      act[c] = 0; tk[c] = 0; mx[c] = 0; my[c] = 0; dn[c] = 0;
    end

    // Reset held with a hit pending: nothing may start.
    Reset = 1'b0; hit1 = 1'b1; hit1_x = 10'd100; hit1_y = 10'd200; frame_tick = 1'b1;
    repeat (3) cyc();
    hit1 = 1'b0; frame_tick = 1'b0;
    Reset = 1'b1;
    cyc();

    // Basic run: 18 ticks to retire, coordinates retained afterwards.
    hit_ch1(100, 200);
    ticks(18);
    repeat (2) cyc();

    // Clamp on channel 2, low-X/high-Y then high-X/low-Y.
    hit_ch2(5, 470);
    ticks(18);
    hit_ch2(639, 0);
    ticks(18);

    // Hit and frame_tick together: tick is dropped.
    frame_tick = 1'b1;
    hit_ch1(50, 60);
    frame_tick = 1'b0;
    ticks(18);

    // Both channels in the same cycle.
    hit1 = 1'b1; hit1_x = 10'd700; hit1_y = 10'd10;
    hit2 = 1'b1; hit2_x = 10'd20;  hit2_y = 10'd900;
    cyc();
    hit1 = 1'b0; hit2 = 1'b0;
    ticks(18);

    // Retrigger attempt in F1.
    hit_ch1(300, 300);
    ticks(8);
    hit_ch1(400, 100);
    ticks(20);

    // Hit in the retire cycle.
    hit_ch1(123, 321);
    ticks(17);
    frame_tick = 1'b1;
    hit_ch1(222, 111);
    frame_tick = 1'b0;
    ticks(20);

    // Reset in the middle of F2: no done pulse, back to IDLE.
    hit_ch2(250, 250);
    ticks(14);
    Reset = 1'b0; cyc();
    Reset = 1'b1;
    repeat (3) cyc();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      Reset      = ($urandom_range(0, 199) != 0);
      frame_tick = ($urandom_range(0, 2) == 0);
      hit1       = ($urandom_range(0, 15) == 0);
      hit2       = ($urandom_range(0, 15) == 0);
      hit1_x     = 10'($urandom_range(0, 1023));
      hit1_y     = 10'($urandom_range(0, 1023));
      hit2_x     = 10'($urandom_range(0, 1023));
      hit2_y     = 10'($urandom_range(0, 1023));
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
